writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
Write-side front end of the register file. Collects completed results from NUM_SRC execution units over valid/ready handshakes and holds each in a one-entry per-source buffer. Each cycle it picks one buffered result round-robin and drives the register file write port (write_valid, use_rw, rw_*, ps_write, ps_*) from registered outputs. The register file is the only consumer.

Parameters:
NUM_SRC, 3, number of execution-unit result sources (>=2)
RA_W, $clog2(`NUM_REG), register address width
PA_W, $clog2(`NUM_PS), predicate address width
DW, `DATA_WIDTH, data width

Ports:
clk  input  1  clock
n_rst  input  1  reset; synchronous, active-low
src_valid  input  NUM_SRC  per-source result valid
src_ready  output  NUM_SRC  per-source buffer can accept
src_use_rw  input  NUM_SRC  source writes a data register
src_rw_addr  input  NUM_SRC*RA_W  packed per-source register addresses
src_rw_data  input  NUM_SRC*DW  packed per-source data
src_ps_write  input  NUM_SRC  source writes a predicate
src_ps_addr  input  NUM_SRC*PA_W  packed per-source predicate addresses
src_ps_data  input  NUM_SRC  per-source predicate value
write_valid  output  1  register file write strobe
use_rw  output  1  data register write enable
rw_addr  output  RA_W  data register address
rw_data  output  DW  data register value
ps_write  output  1  predicate write enable
ps_addr  output  PA_W  predicate address
ps_data  output  1  predicate value
idle  output  1  no buffered entries and write_valid==0

Behaviour:
- Reset (n_rst low at posedge): all buffers empty, rr_ptr=0, write_valid/use_rw/ps_write=0, address and data outputs 0. src_ready forced to 0 while n_rst is low. Reset mid-transfer discards buffered results.
- Handshake: source i transfers when src_valid[i] & src_ready[i] at a posedge. src_ready[i] = ~buf_valid[i] | grant[i]. This is combinational, so a full buffer that is being granted accepts a new entry in the same cycle.
- Null result (src_use_rw[i]=0 and src_ps_write[i]=0): accepted, but the buffer is not loaded. No write is emitted.
- Arbitration (combinational): grant goes to the first i with buf_valid[i], searching from rr_ptr upward modulo NUM_SRC. At most one grant per cycle.
- At a posedge with a grant to g:
  - Outputs load from buffer g with write_valid=1.
  - buf_valid[g] clears, unless it is reloaded by a same-edge handshake.
  - rr_ptr <= (g+1) mod NUM_SRC.
- At a posedge with no grant: write_valid, use_rw and ps_write <= 0. Address and data outputs hold.
- Latency: handshake at edge E, write outputs valid after E+1, register file commits at E+2. Minimum 2 cycles; no bypass path.
- Throughput: one write per cycle total. A single source streaming back-to-back sustains one result per cycle.
- Ordering: per-source FIFO order is preserved. No ordering guarantee across sources.
- Same address from two sources: both writes are emitted in grant order; the later grant wins in the register file.
- Fairness: with all NUM_SRC buffers continuously full, each source is granted exactly once every NUM_SRC cycles.
- Combined writes: use_rw and ps_write may both be 1 in one write. Fields are forwarded unchanged.
- idle = ~|buf_valid & ~write_valid.

Decomposition:
- Shared package nand_cpu_pkg gets a wb_result_t struct {use_rw, rw_addr, rw_data, ps_write, ps_addr, ps_data}. Source ports and buffers use it internally.
- One sub-module, rr_arbiter (NUM_SRC request vector and pointer in, one-hot grant and grant index out), which the issue stage can reuse.

Test Plan:
- Reset, then no stimulus -> write_valid=0 and src_ready=0 while n_rst=0; src_ready='1 and idle=1 after release.
- Src0 sends use_rw=1, rw_addr=5, rw_data=16'h00A5 at edge E -> write_valid=1, rw_addr=5, rw_data=16'h00A5 in the cycle after E+1; write_valid=0 the following cycle.
- All three sources load at the same edge with rw_addr=1,2,3 -> writes emitted on 3 consecutive cycles in order 1,2,3; rr_ptr then wraps to 0.
- Src1 holds valid for 4 back-to-back entries (ps_write=1, ps_addr=0..3, ps_data=1,0,1,0) while src2 stays full -> grants alternate 1,2,1,2; src1 ps writes appear in order 0..3.
- Null result on src2 (use_rw=0, ps_write=0) -> src_ready[2]=1, no write emitted, idle stays 1.
- Src0 and src2 both write rw_addr=7 (data 16'h1111, then 16'h2222) with rr_ptr=1 -> src2 is granted first and src0 second, so the register file ends with 16'h1111 at address 7.

Source files
------------

// File: rtl/nand_cpu_pkg.sv
// Shared types and sizes for the core; wb_result_t is one completed execution result.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nand_cpu_pkg;

    localparam int NUM_REG    = 16;
    localparam int NUM_PS     = 8;
    localparam int DATA_WIDTH = 16;
    localparam int REG_AW     = $clog2(NUM_REG);
    localparam int PS_AW      = $clog2(NUM_PS);

    typedef struct packed {
        logic                  use_rw;
        logic [REG_AW-1:0]     rw_addr;
        logic [DATA_WIDTH-1:0] rw_data;
        logic                  ps_write;
        logic [PS_AW-1:0]      ps_addr;
        logic                  ps_data;
    } wb_result_t;

    // A result that writes neither a register nor a predicate needs no write slot.
    function automatic logic wb_is_null(input wb_result_t r);
        return ~r.use_rw & ~r.ps_write;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or above ptr_i, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          grant_vld_o
);

    // Scan N positions starting at the pointer; the first requester wins.
    always_comb begin
        int j;
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        j           = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!grant_vld_o && req_i[j]) begin
                grant_vld_o = 1'b1;
                grant_o[j]  = 1'b1;
                grant_idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Collects execution results into one-entry per-source buffers and drives the register file write port round-robin.
// Latency: handshake at edge E -> write outputs valid after E+1 (min 2 cycles to commit), no bypass.
// Backpressure: src_ready[i] = buffer empty or buffer granted this cycle; forced low during reset.
module writeback_arbiter
    import nand_cpu_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int RA_W    = REG_AW,
    parameter int PA_W    = PS_AW,
    parameter int DW      = DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NUM_SRC-1:0]     src_valid,
    output logic [NUM_SRC-1:0]     src_ready,
    input  logic [NUM_SRC-1:0]     src_use_rw,
    input  logic [NUM_SRC*RA_W-1:0] src_rw_addr,
    input  logic [NUM_SRC*DW-1:0]  src_rw_data,
    input  logic [NUM_SRC-1:0]     src_ps_write,
    input  logic [NUM_SRC*PA_W-1:0] src_ps_addr,
    input  logic [NUM_SRC-1:0]     src_ps_data,
    output logic                   write_valid,
    output logic                   use_rw,
    output logic [RA_W-1:0]        rw_addr,
    output logic [DW-1:0]          rw_data,
    output logic                   ps_write,
    output logic [PA_W-1:0]        ps_addr,
    output logic                   ps_data,
    output logic                   idle
);

    // RA_W/PA_W/DW must equal the package sizes, since wb_result_t is built from those.
    localparam int IW = $clog2(NUM_SRC);

    wb_result_t               src_res [NUM_SRC];
    wb_result_t               buf_q   [NUM_SRC];
    logic [NUM_SRC-1:0]       buf_vld_q, buf_vld_d;
    logic [NUM_SRC-1:0]       accept, load;
    logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0]       grant;
    logic [IW-1:0]            grant_idx;
    logic                     grant_vld;
    wb_result_t               out_q;
    logic                     write_valid_q;

    // Unpack the flat source ports into per-source result structs.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_res[i].use_rw   = src_use_rw[i];
            src_res[i].rw_addr  = src_rw_addr[i*RA_W +: RA_W];
            src_res[i].rw_data  = src_rw_data[i*DW +: DW];
            src_res[i].ps_write = src_ps_write[i];
            src_res[i].ps_addr  = src_ps_addr[i*PA_W +: PA_W];
            src_res[i].ps_data  = src_ps_data[i];
        end
    end

    rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_rr (
        .req_i       (buf_vld_q),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    // A slot frees in the same cycle it is granted, so a streaming source never bubbles.
    assign src_ready = n_rst ? (~buf_vld_q | grant) : '0;
    assign accept    = src_valid & src_ready;

    // Null results are accepted but never occupy a buffer; a granted buffer clears unless refilled.
    always_comb begin
        load      = '0;
        buf_vld_d = buf_vld_q & ~grant;
        for (int i = 0; i < NUM_SRC; i++) begin
            load[i] = accept[i] & ~wb_is_null(src_res[i]);
            if (load[i]) buf_vld_d[i] = 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == IW'(NUM_SRC - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    // Buffer storage, occupancy and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            buf_vld_q <= '0;
            rr_ptr_q  <= '0;
            for (int i = 0; i < NUM_SRC; i++) buf_q[i] <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            rr_ptr_q  <= rr_ptr_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (load[i]) buf_q[i] <= src_res[i];
            end
        end
    end

    // Registered write port: load the granted entry, otherwise drop the enables and hold address/data.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            write_valid_q <= 1'b0;
            out_q         <= '0;
        end else if (grant_vld) begin
            write_valid_q <= 1'b1;
            out_q         <= buf_q[grant_idx];
        end else begin
            write_valid_q  <= 1'b0;
            out_q.use_rw   <= 1'b0;
            out_q.ps_write <= 1'b0;
        end
    end

    assign write_valid = write_valid_q;
    assign use_rw      = out_q.use_rw;
    assign rw_addr     = out_q.rw_addr;
    assign rw_data     = out_q.rw_data;
    assign ps_write    = out_q.ps_write;
    assign ps_addr     = out_q.ps_addr;
    assign ps_data     = out_q.ps_data;
    assign idle        = ~|buf_vld_q & ~write_valid_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios then randomized traffic with mid-run resets.
// Expected writes come from a queue-based reference model and are checked by an independent monitor.
// Sources are modelled as per-source FIFOs of pending results that advance on accepted handshakes.
module tb_writeback_arbiter;

    localparam int N = 3;

    typedef struct {
        int        cyc;
        bit        use_rw;
        bit [3:0]  rw_addr;
        bit [15:0] rw_data;
        bit        ps_write;
        bit [2:0]  ps_addr;
        bit        ps_data;
    } item_t;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    src_ready;
    logic [N-1:0]    src_use_rw = '0;
    logic [N*4-1:0]  src_rw_addr = '0;
    logic [N*16-1:0] src_rw_data = '0;
    logic [N-1:0]    src_ps_write = '0;
    logic [N*3-1:0]  src_ps_addr = '0;
    logic [N-1:0]    src_ps_data = '0;
    logic            write_valid, use_rw, ps_write, ps_data, idle;
    logic [3:0]      rw_addr;
    logic [15:0]     rw_data;
    logic [2:0]      ps_addr;

    writeback_arbiter #(.NUM_SRC(N)) dut (
        .clk(clk), .n_rst(n_rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_use_rw(src_use_rw), .src_rw_addr(src_rw_addr), .src_rw_data(src_rw_data),
        .src_ps_write(src_ps_write), .src_ps_addr(src_ps_addr), .src_ps_data(src_ps_data),
        .write_valid(write_valid), .use_rw(use_rw), .rw_addr(rw_addr), .rw_data(rw_data),
        .ps_write(ps_write), .ps_addr(ps_addr), .ps_data(ps_data), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state: which sources hold an unwritten result, the fair-share pointer,
    // and whether a write was issued at the last edge.
    item_t     pend [N][$];
    item_t     mbuf [N];
    bit [N-1:0] occ = '0;
    int        ptr = 0;
    bit        mwv = 1'b0;
    bit        model_ok = 1'b0;
    bit        throttle = 1'b0;
    int        edge_n = 0;
    item_t     exp_q [$];
    bit [15:0] rf [16];
    int        addr_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        else n_pass++;
    endtask

    function automatic item_t mk(bit u, int ra, int rd, bit p, int pa, bit pd);
        item_t it;
        it.cyc = 0; it.use_rw = u; it.rw_addr = 4'(ra); it.rw_data = 16'(rd);
        it.ps_write = p; it.ps_addr = 3'(pa); it.ps_data = pd;
        return it;
    endfunction

    // One clock: drive pending heads, check ready/idle, advance the model across the edge.
    task automatic step();
        int g;
        bit [N-1:0] rdy;
        item_t it;
        for (int i = 0; i < N; i++) begin
            it = mk(0, 0, 0, 0, 0, 0);
            if (pend[i].size() > 0) it = pend[i][0];
            src_valid[i]          = (pend[i].size() > 0) && (!throttle || $urandom_range(0, 3) != 0);
            src_use_rw[i]         = it.use_rw;
            src_rw_addr[i*4 +: 4] = it.rw_addr;
            src_rw_data[i*16 +: 16] = it.rw_data;
            src_ps_write[i]       = it.ps_write;
            src_ps_addr[i*3 +: 3] = it.ps_addr;
            src_ps_data[i]        = it.ps_data;
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && occ[(ptr + k) % N]) g = (ptr + k) % N;
        end
        for (int i = 0; i < N; i++) rdy[i] = n_rst && (!occ[i] || g == i);
        #1;
        chk("src_ready", 32'(src_ready), 32'(rdy));
        if (n_rst && model_ok) chk("idle", 32'(idle), 32'(occ == '0 && !mwv));
        @(posedge clk);
        edge_n++;
        if (!n_rst) begin
            occ = '0; ptr = 0; mwv = 1'b0; exp_q.delete(); model_ok = 1'b1;
        end else begin
            mwv = 1'b0;
            if (g >= 0) begin
                it = mbuf[g]; it.cyc = edge_n; exp_q.push_back(it);
                occ[g] = 1'b0; ptr = (g + 1) % N; mwv = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && rdy[i]) begin
                    it = pend[i].pop_front();
                    if (it.use_rw || it.ps_write) begin
                        occ[i] = 1'b1; mbuf[i] = it;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((pend[0].size() + pend[1].size() + pend[2].size() > 0 || occ != '0 || mwv) && b < 200) begin
            step();
            b++;
        end
        chk("drain_timeout", 32'(b < 200), 32'd1);
    endtask

    // Monitor: each write must appear exactly at the edge the model granted it, with matching fields.
    always @(negedge clk) begin
        if (model_ok) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
                chk("missed_write", 32'(exp_q[0].rw_addr), 32'hFFFF);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
                item_t e;
                e = exp_q.pop_front();
                chk("write_valid", 32'(write_valid), 32'd1);
                chk("use_rw", 32'(use_rw), 32'(e.use_rw));
                chk("ps_write", 32'(ps_write), 32'(e.ps_write));
                if (e.use_rw) begin
                    chk("rw_addr", 32'(rw_addr), 32'(e.rw_addr));
                    chk("rw_data", 32'(rw_data), 32'(e.rw_data));
                end
                if (e.ps_write) begin
                    chk("ps_addr", 32'(ps_addr), 32'(e.ps_addr));
                    chk("ps_data", 32'(ps_data), 32'(e.ps_data));
                end
            end else begin
                chk("write_valid_idle", 32'({write_valid, use_rw, ps_write}), 32'd0);
            end
            if (write_valid === 1'b1 && use_rw === 1'b1) begin
                rf[rw_addr] = rw_data;
                addr_log.push_back(int'(rw_addr));
            end
        end
    end

    initial begin
        // Reset: src_ready held low, no writes.
        n_rst = 1'b0;
        repeat (3) step();
        n_rst = 1'b1;
        step();
        chk("ready_after_reset", 32'(src_ready), 32'h7);
        chk("idle_after_reset", 32'(idle), 32'd1);

        // Single write, two-cycle latency.
        pend[0].push_back(mk(1, 5, 16'h00A5, 0, 0, 0));
        drain();
        chk("rf5", 32'(rf[5]), 32'h00A5);

        // Bring pointer back to 0 with a predicate write on source 2.
        pend[2].push_back(mk(0, 0, 0, 1, 6, 1));
        drain();

        // Three simultaneous loads emerge in order 1,2,3.
        addr_log.delete();
        pend[0].push_back(mk(1, 1, 16'h0101, 0, 0, 0));
        pend[1].push_back(mk(1, 2, 16'h0202, 0, 0, 0));
        pend[2].push_back(mk(1, 3, 16'h0303, 0, 0, 0));
        drain();
        chk("order_len", 32'(addr_log.size()), 32'd3);
        if (addr_log.size() == 3) chk("order", 32'({addr_log[0][3:0], addr_log[1][3:0], addr_log[2][3:0]}), 32'h123);

        // Source 1 streams 4 predicate writes while source 2 stays busy.
        for (int k = 0; k < 4; k++) begin
            pend[1].push_back(mk(0, 0, 0, 1, k, (k % 2) == 0));
            pend[2].push_back(mk(1, 8 + k, 16'h2000 + k, 0, 0, 0));
        end
        drain();

        // Null result is swallowed: ready stays high, idle stays high, no write.
        pend[2].push_back(mk(0, 0, 0, 0, 0, 0));
        repeat (3) step();

        // Same address from two sources with pointer at 1: source 2 first, source 0 last.
        pend[0].push_back(mk(1, 9, 16'h0009, 0, 0, 0));
        drain();
        pend[0].push_back(mk(1, 7, 16'h1111, 0, 0, 0));
        pend[2].push_back(mk(1, 7, 16'h2222, 0, 0, 0));
        drain();
        chk("rf7_last_grant_wins", 32'(rf[7]), 32'h1111);

        // Randomized traffic with throttled sources, combined writes, nulls and occasional resets.
        throttle = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i].size() < 4 && $urandom_range(0, 2) != 0)
                    pend[i].push_back(mk($urandom_range(0, 1) == 1, $urandom_range(0, 15),
                        $urandom_range(0, 65535), $urandom_range(0, 1) == 1,
                        $urandom_range(0, 7), $urandom_range(0, 1) == 1));
            end
            if ($urandom_range(0, 299) == 0) begin
                n_rst = 1'b0;
                repeat (2) step();
                n_rst = 1'b1;
            end
            step();
        end
        throttle = 1'b0;
        drain();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
